// File: rtl/cprv_mem_arbiter_if.sv
// cprv_mem_arbiter_if: request/response and memory-side bus of the IF/MEM memory arbiter
// Fetch port   : valid_imem_i/ready_imem_o/instr_addr_imem_i request, valid_if_o/ready_if_i/instr_data_if_o response
// Data port    : valid_dmem_i/ready_dmem_o/addr_dmem_i/wdata_dmem_i/w_en_dmem_i request,
//                valid_mem_dmem_o/ready_mem_dmem_i/rdata_dmem_o response
// Memory port  : mem_valid_o/mem_ready_i/mem_addr_o/mem_w_en_o/mem_wdata_o request, mem_rvalid_i/mem_rdata_i response
// slave modport is the arbiter's view, master is the view of the requesters plus memory.
interface cprv_mem_arbiter_if #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 64
);
    logic                  valid_imem_i;
    logic                  ready_imem_o;
    logic [ADDR_WIDTH-1:0] instr_addr_imem_i;
    logic                  valid_if_o;
    logic                  ready_if_i;
    logic [31:0]           instr_data_if_o;
    logic                  valid_dmem_i;
    logic                  ready_dmem_o;
    logic [ADDR_WIDTH-1:0] addr_dmem_i;
    logic [DATA_WIDTH-1:0] wdata_dmem_i;
    logic                  w_en_dmem_i;
    logic                  valid_mem_dmem_o;
    logic                  ready_mem_dmem_i;
    logic [DATA_WIDTH-1:0] rdata_dmem_o;
    logic                  mem_valid_o;
    logic                  mem_ready_i;
    logic [ADDR_WIDTH-1:0] mem_addr_o;
    logic                  mem_w_en_o;
    logic [DATA_WIDTH-1:0] mem_wdata_o;
    logic                  mem_rvalid_i;
    logic [DATA_WIDTH-1:0] mem_rdata_i;

    modport slave (
        input  valid_imem_i, instr_addr_imem_i, ready_if_i,
               valid_dmem_i, addr_dmem_i, wdata_dmem_i, w_en_dmem_i, ready_mem_dmem_i,
               mem_ready_i, mem_rvalid_i, mem_rdata_i,
        output ready_imem_o, valid_if_o, instr_data_if_o,
               ready_dmem_o, valid_mem_dmem_o, rdata_dmem_o,
               mem_valid_o, mem_addr_o, mem_w_en_o, mem_wdata_o
    );

    modport master (
        output valid_imem_i, instr_addr_imem_i, ready_if_i,
               valid_dmem_i, addr_dmem_i, wdata_dmem_i, w_en_dmem_i, ready_mem_dmem_i,
               mem_ready_i, mem_rvalid_i, mem_rdata_i,
        input  ready_imem_o, valid_if_o, instr_data_if_o,
               ready_dmem_o, valid_mem_dmem_o, rdata_dmem_o,
               mem_valid_o, mem_addr_o, mem_w_en_o, mem_wdata_o
    );
endinterface

// File: rtl/cprv_mem_arbiter.sv
// cprv_mem_arbiter: shares one single-ported memory between instruction fetch and the data port
// Ports: clk (rising edge), rst_n (async, active-low), bus (cprv_mem_arbiter_if.slave) carrying
// the fetch request/response, data request/response and memory request/response channels.
// One transaction in flight at a time; data wins arbitration until STARVE_LIMIT consecutive
// data grants have been given while a fetch waited, then fetch is served.
module cprv_mem_arbiter #(
    parameter int DATA_WIDTH   = 64,
    parameter int ADDR_WIDTH   = 64,
    parameter int STARVE_LIMIT = 4
) (
    input logic clk,
    input logic rst_n,
    cprv_mem_arbiter_if.slave bus
);
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t                state, state_nx;
    logic [SW-1:0]         streak;
    logic                  owner_i;
    logic                  w_en_q;
    logic                  sel_hi;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] rbuf;
    logic                  grant_i;
    logic                  grant_d;
    logic                  resp_taken;

    // Grant doubles as ready, so a grant is also the handshake; gated by rst_n so every
    // output reads 0 while reset is held.
    assign grant_d    = rst_n && state == IDLE && bus.valid_dmem_i &&
                        (!bus.valid_imem_i || streak < SW'(STARVE_LIMIT));
    assign grant_i    = rst_n && state == IDLE && bus.valid_imem_i && !grant_d;
    assign resp_taken = owner_i ? bus.ready_if_i : bus.ready_mem_dmem_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = (grant_i || grant_d) ? ISSUE : IDLE;
            ISSUE:   state_nx = bus.mem_ready_i ? WAIT : ISSUE;
            WAIT:    state_nx = bus.mem_rvalid_i ? RESP : WAIT;
            RESP:    state_nx = resp_taken ? IDLE : RESP;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        bus.ready_imem_o     = grant_i;
        bus.ready_dmem_o     = grant_d;
        bus.mem_valid_o      = state == ISSUE;
        bus.mem_addr_o       = bus.mem_valid_o ? addr_q : '0;
        bus.mem_w_en_o       = bus.mem_valid_o && w_en_q;
        bus.mem_wdata_o      = bus.mem_valid_o ? wdata_q : '0;
        bus.valid_if_o       = state == RESP && owner_i;
        bus.instr_data_if_o  = !bus.valid_if_o ? '0 : sel_hi ? rbuf[32 +: 32] : rbuf[31:0];
        bus.valid_mem_dmem_o = state == RESP && !owner_i;
        bus.rdata_dmem_o     = (bus.valid_mem_dmem_o && !w_en_q) ? rbuf : '0;
    end

    // Fetch latches zero write data/enable so the memory sees a clean read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            streak  <= '0;
            owner_i <= 1'b0;
            w_en_q  <= 1'b0;
            sel_hi  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rbuf    <= '0;
        end else begin
            if (grant_i || grant_d) begin
                owner_i <= grant_i;
                addr_q  <= grant_i ? bus.instr_addr_imem_i : bus.addr_dmem_i;
                wdata_q <= grant_d ? bus.wdata_dmem_i : '0;
                w_en_q  <= grant_d && bus.w_en_dmem_i;
                sel_hi  <= grant_i && bus.instr_addr_imem_i[2];
                streak  <= (bus.valid_imem_i && bus.valid_dmem_i && grant_d) ? streak + SW'(1) : '0;
            end
            if (state == WAIT && bus.mem_rvalid_i)
                rbuf <= bus.mem_rdata_i;
        end
    end
endmodule

// File: tb/tb_cprv_mem_arbiter.sv
// tb_cprv_mem_arbiter: directed bench with a transaction-level reference model and per-cycle compare
module tb_cprv_mem_arbiter;
    localparam int LIMIT = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cprv_mem_arbiter_if bus ();

    cprv_mem_arbiter #(.DATA_WIDTH(64), .ADDR_WIDTH(64), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;
    int dut_log[$];
    int m_log[$];
    int exp_order[10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    logic log_en;

    // Memory contents: one distinctive word around 0x1000, otherwise derived from the address.
    function automatic logic [63:0] mem_word(input logic [63:0] a);
        return (a[63:3] == 61'h200) ? 64'hAAAA_BBBB_CCCC_DDDD : {32'hD000_0000 | a[31:0], ~a[31:0]};
    endfunction

    // Memory responder: one response the cycle after each accepted request, or a forced one.
    logic        mv_s;
    logic [63:0] ma_s;
    logic        auto_en;
    logic        force_rv;
    logic [63:0] force_data;
    always @(negedge clk) begin
        mv_s <= bus.mem_valid_o;
        ma_s <= bus.mem_addr_o;
    end
    always @(posedge clk) begin : responder
        logic        acc;
        logic        fr;
        logic [63:0] a;
        acc = rst_n && mv_s && bus.mem_ready_i && auto_en;
        fr  = force_rv;
        a   = ma_s;
        #1;
        bus.mem_rvalid_i = acc || fr;
        bus.mem_rdata_i  = fr ? force_data : acc ? mem_word(a) : 64'h0;
    end

    // Reference model: one outstanding transaction described by flags.
    logic        m_busy, m_owner_i, m_wen, m_acc, m_ret;
    logic [63:0] m_addr, m_wdata, m_data;
    int          m_streak;
    logic        m_gd, m_gi;
    assign m_gd = !m_busy && bus.valid_dmem_i && (!bus.valid_imem_i || m_streak < LIMIT);
    assign m_gi = !m_busy && bus.valid_imem_i && !m_gd;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 0; m_owner_i <= 0; m_wen <= 0; m_acc <= 0; m_ret <= 0;
            m_addr <= 0; m_wdata <= 0; m_data <= 0; m_streak <= 0;
        end else if (!m_busy) begin
            if (m_gd || m_gi) begin
                m_busy    <= 1;
                m_owner_i <= m_gi;
                m_addr    <= m_gi ? bus.instr_addr_imem_i : bus.addr_dmem_i;
                m_wen     <= m_gd && bus.w_en_dmem_i;
                m_wdata   <= m_gd ? bus.wdata_dmem_i : 64'h0;
                m_acc     <= 0;
                m_ret     <= 0;
                m_streak  <= (bus.valid_imem_i && bus.valid_dmem_i && m_gd) ? m_streak + 1 : 0;
                if (log_en) m_log.push_back(m_gi ? 1 : 0);
            end
        end else if (!m_acc) begin
            m_acc <= bus.mem_ready_i;
        end else if (!m_ret) begin
            if (bus.mem_rvalid_i) begin
                m_ret  <= 1;
                m_data <= bus.mem_rdata_i;
            end
        end else if (m_owner_i ? bus.ready_if_i : bus.ready_mem_dmem_i) begin
            m_busy <= 0;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic any_out();
        return bus.ready_imem_o | bus.ready_dmem_o | bus.valid_if_o | (|bus.instr_data_if_o) |
               bus.valid_mem_dmem_o | (|bus.rdata_dmem_o) | bus.mem_valid_o | (|bus.mem_addr_o) |
               bus.mem_w_en_o | (|bus.mem_wdata_o);
    endfunction

    task automatic compare();
        logic rv_i, rv_d;
        if (!rst_n) begin
            chk("reset_outputs", any_out(), 0);
            return;
        end
        rv_i = m_busy && m_ret && m_owner_i;
        rv_d = m_busy && m_ret && !m_owner_i;
        chk("ready_imem", bus.ready_imem_o, m_gi);
        chk("ready_dmem", bus.ready_dmem_o, m_gd);
        chk("mem_valid", bus.mem_valid_o, m_busy && !m_acc);
        if (m_busy && !m_acc) begin
            chk("mem_addr", bus.mem_addr_o, m_addr);
            chk("mem_w_en", bus.mem_w_en_o, m_wen);
            chk("mem_wdata", bus.mem_wdata_o, m_wdata);
        end
        chk("valid_if", bus.valid_if_o, rv_i);
        chk("valid_mem_dmem", bus.valid_mem_dmem_o, rv_d);
        if (rv_i) chk("instr_data", bus.instr_data_if_o, m_addr[2] ? m_data[63:32] : m_data[31:0]);
        if (rv_d) chk("rdata_dmem", bus.rdata_dmem_o, m_wen ? 64'h0 : m_data);
        if (log_en && ((bus.ready_imem_o && bus.valid_imem_i) || (bus.ready_dmem_o && bus.valid_dmem_i)))
            dut_log.push_back(bus.ready_imem_o ? 1 : 0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_resp(input logic fetch, output int n);
        n = 1;
        while (!(fetch ? bus.valid_if_o : bus.valid_mem_dmem_o) && n < 20) begin
            step();
            n++;
        end
    endtask

    initial begin
        int n;
        bus.valid_imem_i = 0; bus.instr_addr_imem_i = 0; bus.ready_if_i = 1;
        bus.valid_dmem_i = 0; bus.addr_dmem_i = 0; bus.wdata_dmem_i = 0; bus.w_en_dmem_i = 0;
        bus.ready_mem_dmem_i = 1; bus.mem_ready_i = 1; bus.mem_rvalid_i = 0; bus.mem_rdata_i = 0;
        auto_en = 1; force_rv = 0; force_data = 0; log_en = 0;
        fork
            forever begin
                @(negedge clk);
                compare();
            end
        join_none
        repeat (2) @(posedge clk);
        #1 rst_n = 1;

        // Fetch of the high word, zero-wait latency
        bus.valid_imem_i = 1; bus.instr_addr_imem_i = 64'h1004;
        step();
        bus.valid_imem_i = 0;
        chk("t1_mem_valid", bus.mem_valid_o, 1);
        chk("t1_mem_addr", bus.mem_addr_o, 64'h1004);
        chk("t1_mem_w_en", bus.mem_w_en_o, 0);
        wait_resp(1, n);
        chk("t1_latency", n, 3);
        chk("t1_instr", bus.instr_data_if_o, 32'hAAAA_BBBB);
        step();

        // Store, then a load
        bus.valid_dmem_i = 1; bus.addr_dmem_i = 64'h2000; bus.wdata_dmem_i = 64'h1234; bus.w_en_dmem_i = 1;
        step();
        bus.valid_dmem_i = 0; bus.w_en_dmem_i = 0;
        chk("t2_mem_w_en", bus.mem_w_en_o, 1);
        chk("t2_mem_wdata", bus.mem_wdata_o, 64'h1234);
        wait_resp(0, n);
        chk("t2_latency", n, 3);
        chk("t2_store_rdata", bus.rdata_dmem_o, 0);
        step();
        bus.valid_dmem_i = 1; bus.addr_dmem_i = 64'h3000;
        step();
        bus.valid_dmem_i = 0;
        wait_resp(0, n);
        chk("t2_load_rdata", bus.rdata_dmem_o, 64'hD000_3000_FFFF_CFFF);
        step();

        // Both requesters continuously valid: starvation cap
        bus.instr_addr_imem_i = 64'h4000; bus.addr_dmem_i = 64'h5000;
        log_en = 1; bus.valid_imem_i = 1; bus.valid_dmem_i = 1;
        n = 0;
        while (dut_log.size() < 10 && n < 80) begin
            step();
            n++;
        end
        bus.valid_imem_i = 0; bus.valid_dmem_i = 0; log_en = 0;
        chk("t3_grant_count", dut_log.size(), 10);
        chk("t3_cycles", n, 37);
        for (int i = 0; i < 10; i++) begin
            if (i < dut_log.size()) chk($sformatf("t3_dut_order%0d", i), dut_log[i], exp_order[i]);
            if (i < m_log.size()) chk($sformatf("t3_model_order%0d", i), m_log[i], exp_order[i]);
        end
        repeat (5) step();

        // Memory stalls in ISSUE and response held in RESP while data waits
        bus.mem_ready_i = 0; bus.ready_if_i = 0;
        bus.valid_imem_i = 1; bus.instr_addr_imem_i = 64'h1008;
        step();
        bus.valid_imem_i = 0; bus.valid_dmem_i = 1; bus.addr_dmem_i = 64'h6000;
        for (int k = 0; k < 3; k++) begin
            chk("t4_mem_valid", bus.mem_valid_o, 1);
            chk("t4_mem_addr", bus.mem_addr_o, 64'h1008);
            chk("t4_ready_dmem_busy", bus.ready_dmem_o, 0);
            step();
        end
        bus.mem_ready_i = 1;
        n = 0;
        while (!bus.valid_if_o && n < 20) begin
            step();
            n++;
        end
        chk("t4_resp_wait", n, 2);
        for (int k = 0; k < 2; k++) begin
            chk("t4_valid_if_held", bus.valid_if_o, 1);
            chk("t4_instr_held", bus.instr_data_if_o, 32'hFFFF_EFF7);
            chk("t4_ready_dmem_resp", bus.ready_dmem_o, 0);
            step();
        end
        bus.ready_if_i = 1;
        step();
        chk("t4_ready_dmem_after", bus.ready_dmem_o, 1);
        step();
        bus.valid_dmem_i = 0;
        wait_resp(0, n);
        chk("t4_load_rdata", bus.rdata_dmem_o, 64'hD000_6000_FFFF_9FFF);
        step();

        // Reset while waiting on memory, then a stray response in IDLE
        auto_en = 0;
        bus.valid_imem_i = 1; bus.instr_addr_imem_i = 64'h1000;
        step();
        bus.valid_imem_i = 0;
        step();
        #2 rst_n = 0;
        #1 chk("t5_async_reset", any_out(), 0);
        step();
        rst_n = 1;
        force_rv = 1; force_data = 64'hDEAD_BEEF_0000_0001;
        step();
        force_rv = 0;
        chk("t5_late_rvalid_seen", bus.mem_rvalid_i, 1);
        chk("t5_late_mem_valid", bus.mem_valid_o, 0);
        chk("t5_late_valid_if", bus.valid_if_o, 0);
        step();
        chk("t5_after_valid_if", bus.valid_if_o, 0);
        chk("t5_after_valid_mem", bus.valid_mem_dmem_o, 0);
        auto_en = 1;

        // Low-word fetch, then a request withdrawn before acceptance
        bus.valid_imem_i = 1; bus.instr_addr_imem_i = 64'h1000;
        step();
        bus.valid_imem_i = 0;
        wait_resp(1, n);
        chk("t6_latency", n, 3);
        chk("t6_instr", bus.instr_data_if_o, 32'hCCCC_DDDD);
        step();
        bus.valid_imem_i = 1; bus.instr_addr_imem_i = 64'h7000;
        #2 chk("t6_ready_pulse", bus.ready_imem_o, 1);
        bus.valid_imem_i = 0;
        step();
        chk("t6_no_mem_valid0", bus.mem_valid_o, 0);
        step();
        chk("t6_no_mem_valid1", bus.mem_valid_o, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
